iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning operand/result width in bits (legal: 8..64, power of two).
REQ-002 The module SHALL have derived localparam SHW = clog2(WIDTH), meaning shift-amount width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  request accepted when in_valid and in_ready both high at a rising edge.
REQ-007 op  input  4  opcode, encodings from the shared opcode definitions.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 cin  input  1  carry/borrow in, used by ADD/SUB only.
REQ-010 shamt  input  SHW  shift/rotate amount, used by shift-class opcodes only.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  result consumed when out_valid and out_ready both high at a rising edge.
REQ-013 c  output  WIDTH  registered result.
REQ-014 cout  output  1  registered carry/borrow out.
REQ-015 zero  output  1  registered flag, high when c equals 0.

Function
REQ-016 Opcodes SHALL be: ADD=0, SUB=1, ID=2, NAND=3, NOR=4, XNOR=5, NOT=6, AND=7, OR=8, XOR=9, LRS=10, ARS=11, RR=12, LLS=13, ALS=14, RL=15.
REQ-017 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-018 An accepted request SHALL latch op, a, b, cin and shamt.
REQ-019 Opcodes 0-9 SHALL go IDLE->DONE, with out_valid high on the first edge after acceptance (latency 1).
REQ-020 Opcodes 10-15 SHALL go IDLE->SHIFT, move the working register one bit per cycle for shamt cycles, then go to DONE (latency shamt+1); shamt=0 SHALL go directly to DONE with c=a.
REQ-021 ADD SHALL compute {cout,c} = a+b+cin at WIDTH+1 bits.
REQ-022 SUB SHALL compute c = (a-b-cin) mod 2^WIDTH, with cout=1 exactly when unsigned a < b+cin.
REQ-023 All non-ADD/SUB opcodes SHALL drive cout=0.
REQ-024 Bitwise ops SHALL act on a and b; ID and NOT SHALL use a only.
REQ-025 ARS SHALL replicate the MSB of a; ALS SHALL equal LLS; RR/RL SHALL rotate through WIDTH bits.
REQ-026 in_ready SHALL be high in IDLE, and also in DONE while out_ready is high (back-to-back accept); it SHALL be low in SHIFT.
REQ-027 In DONE with out_ready low, c, cout, zero and out_valid SHALL hold stable.
REQ-028 If DONE handshakes and in_valid is high in the same cycle, the new request SHALL be accepted and the next state chosen per REQ-019/020.
REQ-029 If DONE handshakes and in_valid is low, the FSM SHALL return to IDLE and out_valid SHALL fall.
REQ-030 out_valid SHALL be high only in DONE.
REQ-031 Inputs other than in_valid and out_ready SHALL be ignored outside an accepting cycle.

Reset
REQ-032 While reset is high at a rising edge, the FSM SHALL enter IDLE and c, cout, zero and out_valid SHALL go to 0.
REQ-033 in_ready SHALL be 1 on the first cycle after reset, and no request SHALL be accepted while reset is high.
REQ-034 Reset asserted mid-SHIFT or in DONE SHALL discard the operation with no result produced.

Structure
REQ-035 The opcode constants SHALL reside in the shared opcodes definition file, reused by all ALU variants.
REQ-036 One sub-module, iter_alu_shifter (one-step shift/rotate of the working register by opcode), SHALL be instantiated; all other logic SHALL be in iter_alu.

Verification
REQ-037 WIDTH=16, ADD a=16'hFFFF b=16'h0001 cin=0 -> next edge: out_valid=1, c=16'h0000, cout=1, zero=1.
REQ-038 SUB a=16'h0003 b=16'h0005 cin=1 -> c=16'hFFFD, cout=1; SUB a=5 b=3 cin=0 -> c=16'h0002, cout=0.
REQ-039 ARS a=16'h8000 shamt=3 -> out_valid after 4 edges, c=16'hF000; RL a=16'h8001 shamt=1 -> c=16'h0003; LLS shamt=0 a=16'h1234 -> c=16'h1234 after 1 edge.
REQ-040 Hold out_ready=0 for 5 cycles after XOR a=16'hF0F0 b=16'hFF00 -> c=16'h0FF0 stable and in_ready=0; then out_ready=1 with in_valid=1 (AND) -> accepted same edge, AND result on the next edge.
REQ-041 Assert reset 2 cycles into LLS shamt=7 -> next cycle out_valid=0, in_ready=1, c=0, and no result is emitted.
REQ-042 WIDTH=8, ADD a=8'hFF b=8'h01 cin=1 -> c=8'h01, cout=1; RR a=8'h01 shamt=7 -> c=8'h02.

Source files
------------

// File: rtl/iter_alu_pkg.sv
// Shared opcode definitions for the ALU family, plus FSM state encoding
// and a helper that classifies shift-class opcodes.
package iter_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_ID   = 4'd2,
      OP_NAND = 4'd3,
      OP_NOR  = 4'd4,
      OP_XNOR = 4'd5,
      OP_NOT  = 4'd6,
      OP_AND  = 4'd7,
      OP_OR   = 4'd8,
      OP_XOR  = 4'd9,
      OP_LRS  = 4'd10,
      OP_ARS  = 4'd11,
      OP_RR   = 4'd12,
      OP_LLS  = 4'd13,
      OP_ALS  = 4'd14,
      OP_RL   = 4'd15
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op >= OP_LRS);
   endfunction

endpackage

// File: rtl/iter_alu_shifter.sv
// One-step shift/rotate of the working register, selected by opcode.
module iter_alu_shifter
   import iter_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      dout = din;
      case (op_t'(op))
         OP_LRS:         dout = {1'b0, din[WIDTH-1:1]};
         OP_ARS:         dout = {din[WIDTH-1], din[WIDTH-1:1]};
         OP_RR:          dout = {din[0], din[WIDTH-1:1]};
         OP_LLS, OP_ALS: dout = {din[WIDTH-2:0], 1'b0};
         OP_RL:          dout = {din[WIDTH-2:0], din[WIDTH-1]};
         default:        dout = din;
      endcase
   end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle arithmetic/logic ops, bit-serial shifts and
// rotates, valid/ready handshakes on both request and result sides.
module iter_alu
   import iter_alu_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             cout,
   output logic             zero
);

   state_t           state, state_nxt;
   logic             load, step;
   logic [3:0]       op_r;
   logic [SHW-1:0]   cnt;
   logic [WIDTH:0]   alu_wide;
   logic [WIDTH-1:0] sh_out;

   // Shift-class opcodes load a here and are walked by the shifter afterwards.
   always_comb begin
      alu_wide = {1'b0, a};
      case (op_t'(op))
         OP_ADD:  alu_wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
         OP_SUB:  alu_wide = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
         OP_ID:   alu_wide = {1'b0, a};
         OP_NAND: alu_wide = {1'b0, ~(a & b)};
         OP_NOR:  alu_wide = {1'b0, ~(a | b)};
         OP_XNOR: alu_wide = {1'b0, ~(a ^ b)};
         OP_NOT:  alu_wide = {1'b0, ~a};
         OP_AND:  alu_wide = {1'b0, a & b};
         OP_OR:   alu_wide = {1'b0, a | b};
         OP_XOR:  alu_wide = {1'b0, a ^ b};
         default: alu_wide = {1'b0, a};
      endcase
   end

   iter_alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .op   (op_r),
      .din  (c),
      .dout (sh_out)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            load     = in_valid;
         end
         ST_SHIFT: begin
            step = 1'b1;
            if (cnt == SHW'(1)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               in_ready = 1'b1;
               load     = in_valid;
               if (!in_valid) state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (load) state_nxt = (is_shift_op(op) && shamt != '0) ? ST_SHIFT : ST_DONE;
   end

   assign out_valid = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         c    <= '0;
         cout <= 1'b0;
         zero <= 1'b0;
      end else if (load) begin
         c    <= alu_wide[WIDTH-1:0];
         cout <= alu_wide[WIDTH];
         zero <= (alu_wide[WIDTH-1:0] == '0);
      end else if (step) begin
         c    <= sh_out;
         zero <= (sh_out == '0);
      end
   end

   // Opcode and remaining step count; meaningless outside SHIFT so not reset.
   always_ff @(posedge clk) begin
      if (load) begin
         op_r <= op;
         cnt  <= shamt;
      end else if (step) begin
         cnt <= cnt - SHW'(1);
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: directed cases, backpressure, reset abort and random
// ops against an arithmetic reference model; a WIDTH=8 copy runs alongside.
module tb_iter_alu;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready, in_ready8;
   logic [3:0]  op;
   logic [15:0] a, b;
   logic        cin;
   logic [3:0]  shamt;
   logic        out_valid, out_valid8;
   logic        out_ready;
   logic [15:0] c;
   logic [7:0]  c8;
   logic        cout, cout8, zero, zero8;

   int tests = 0;
   int fails = 0;

   iter_alu #(.WIDTH(16)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .cin(cin), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready),
      .c(c), .cout(cout), .zero(zero)
   );

   iter_alu #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
      .op(op), .a(a[7:0]), .b(b[7:0]), .cin(cin), .shamt(shamt[2:0]),
      .out_valid(out_valid8), .out_ready(out_ready),
      .c(c8), .cout(cout8), .zero(zero8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on a 16-bit machine.
   task automatic model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic [3:0] s,
                        output logic [15:0] r, output logic co);
      int t;
      int n;
      n  = int'(s);
      co = 1'b0;
      t  = 0;
      case (o)
         4'd0: begin t = int'(x) + int'(y) + int'(ci); r = t[15:0]; co = (t > 65535); end
         4'd1: begin t = int'(x) - int'(y) - int'(ci); r = t[15:0]; co = (int'(x) < int'(y) + int'(ci)); end
         4'd2: r = x;
         4'd3: r = ~(x & y);
         4'd4: r = ~(x | y);
         4'd5: r = ~(x ^ y);
         4'd6: r = ~x;
         4'd7: r = x & y;
         4'd8: r = x | y;
         4'd9: r = x ^ y;
         4'd10: r = x >> n;
         4'd11: begin t = int'($signed(x)) >>> n; r = t[15:0]; end
         4'd12: r = (n == 0) ? x : ((x >> n) | (x << (16 - n)));
         4'd13, 4'd14: r = x << n;
         default: r = (n == 0) ? x : ((x << n) | (x >> (16 - n)));
      endcase
   endtask

   task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic [3:0] s,
                        input bit do8, input logic [7:0] e8, input logic e8co);
      logic [15:0] er;
      logic        eco;
      int          lat, exp_lat;
      model(o, x, y, ci, s, er, eco);
      exp_lat = (o >= 4'd10) ? int'(s) + 1 : 1;
      @(negedge clk);
      op = o; a = x; b = y; cin = ci; shamt = s;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("in_ready_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); shamt = 4'($urandom);
      lat = 1;
      if (exp_lat > 1) chk("in_ready_shift", 32'(in_ready), 32'd0);
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("c", 32'(c), 32'(er));
      chk("cout", 32'(cout), 32'(eco));
      chk("zero", 32'(zero), 32'(er == 16'h0000));
      if (do8) begin
         chk("c8", 32'(c8), 32'(e8));
         chk("cout8", 32'(cout8), 32'(e8co));
         chk("valid8", 32'(out_valid8), 32'd1);
      end
      @(posedge clk);
      #1 chk("out_valid_fall", 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic        seen;
      logic [3:0]  ro, rs;
      logic [15:0] ra, rb;

      // Request held high during reset must not be taken.
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      op = 4'd0; a = 16'h0001; b = 16'h0001; cin = 1'b0; shamt = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_c", 32'(c), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid8", 32'(out_valid8), 32'd0);
      reset = 1'b0; in_valid = 1'b0;

      issue(4'd0, 16'hFFFF, 16'h0001, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
      chk("add_wrap_c", 32'(c), 32'h0000);
      issue(4'd1, 16'h0003, 16'h0005, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0);
      chk("sub_borrow_c", 32'(c), 32'hFFFD);
      issue(4'd1, 16'h0005, 16'h0003, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
      issue(4'd11, 16'h8000, 16'h0000, 1'b0, 4'd3, 1'b0, 8'h00, 1'b0);
      chk("ars_c", 32'(c), 32'hF000);
      issue(4'd15, 16'h8001, 16'h0000, 1'b0, 4'd1, 1'b0, 8'h00, 1'b0);
      chk("rl_c", 32'(c), 32'h0003);
      issue(4'd13, 16'h1234, 16'h0000, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
      issue(4'd0, 16'h00FF, 16'h0001, 1'b1, 4'd0, 1'b1, 8'h01, 1'b1);
      issue(4'd12, 16'h0001, 16'h0000, 1'b0, 4'd7, 1'b1, 8'h02, 1'b0);
      issue(4'd12, 16'h0001, 16'h0000, 1'b0, 4'd15, 1'b0, 8'h00, 1'b0);

      // Result held under backpressure, then a back-to-back accept.
      @(negedge clk);
      out_ready = 1'b0; op = 4'd9; a = 16'hF0F0; b = 16'hFF00; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; a = 16'h5555; b = 16'hAAAA; op = 4'd0;
      chk("bp_first_valid", 32'(out_valid), 32'd1);
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_c", 32'(c), 32'h0FF0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      op = 4'd7; a = 16'hF0F0; b = 16'hFF00; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_c", 32'(c), 32'hF000);
      chk("b2b_cout", 32'(cout), 32'd0);
      @(posedge clk);
      #1 chk("b2b_fall", 32'(out_valid), 32'd0);

      // Reset two cycles into a long shift discards it.
      @(negedge clk);
      op = 4'd13; a = 16'h0001; b = 16'h0000; shamt = 4'd7; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_c", 32'(c), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1 seen = seen | out_valid;
      end
      chk("abort_no_result", 32'(seen), 32'd0);

      for (int i = 0; i < 60; i++) begin
         ro = 4'($urandom);
         rs = 4'($urandom);
         ra = (i % 10 == 0) ? 16'h0000 : 16'($urandom);
         rb = (i % 7 == 0) ? 16'hFFFF : 16'($urandom);
         issue(ro, ra, rb, 1'($urandom), rs, 1'b0, 8'h00, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
